// File: rtl/plot_arbiter.sv
// plot_arbiter
//
// Multiplexes up to four sprite-plotter pixel streams (obstacle FSMs, player
// drawer, background clearer) onto the single VGA adapter write port. Whole
// bursts are granted, one sprite per grant, in round-robin order so that no
// requester starves. The selected pixel is registered before the adapter.
//
// Optional feature (macro PLOT_ARBITER_TIMEOUT_EN): an idle-write watchdog
// releases a granted requester that stops writing for TIMEOUT cycles and
// sets the sticky timeout_err flag. Without the macro a stalled requester
// holds the port indefinitely and timeout_err is tied 0.
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   req[3:0]     per-requester burst request, held until the burst ends
//   last[3:0]    per-requester "this write is the final pixel" flag
//   we_in[3:0]   per-requester pixel write strobe
//   x_in         packed x, requester k at [k*X_W +: X_W]
//   y_in         packed y, same packing
//   colour_in    packed colour, same packing
//   grant[3:0]   one-hot (or zero) burst grant, registered
//   x, y, colour registered pixel to the VGA adapter
//   writeEn      registered pixel write strobe to the adapter
//   busy         high while any grant is held
//   timeout_err  sticky forced-release flag (0 without the feature)

module plot_arbiter #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int C_W     = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [3:0]       we_in,
    input  logic [4*X_W-1:0] x_in,
    input  logic [4*Y_W-1:0] y_in,
    input  logic [4*C_W-1:0] colour_in,
    output logic [3:0]       grant,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [C_W-1:0]   colour,
    output logic             writeEn,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [0:0] {StIdle, StBusy} state_t;

    state_t         r_state;
    logic   [3:0]   r_grant;
    logic   [1:0]   r_gidx;     // index of the current grant holder
    logic   [1:0]   r_ptr;      // round-robin highest-priority requester
    logic           r_busy;
    logic   [X_W-1:0] r_x;
    logic   [Y_W-1:0] r_y;
    logic   [C_W-1:0] r_colour;
    logic           r_we;

    state_t         w_state_nxt;
    logic   [3:0]   w_grant_nxt;
    logic   [1:0]   w_gidx_nxt;
    logic   [1:0]   w_ptr_nxt;
    logic           w_win_vld;
    logic   [1:0]   w_win_idx;
    logic           w_acc;
    logic           w_timeout;
    logic           w_release;

    // Round-robin search: scan ptr+3 down to ptr+0 so the nearest set bit
    // (lowest offset from ptr) is the last one written and therefore wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            logic [1:0] idx;
            idx = r_ptr + 2'(i);
            if (req[idx]) begin
                w_win_vld = 1'b1;
                w_win_idx = idx;
            end
        end
    end

    // Only the grant holder's strobe is ever looked at; writes from anyone
    // else, including a requester whose grant is not yet visible, are dropped.
    assign w_acc = (r_state == StBusy) && we_in[r_gidx];

`ifdef PLOT_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;

    // r_cnt counts idle BUSY cycles already seen; this cycle being idle as
    // well makes TIMEOUT idle cycles in a row.
    assign w_timeout = (r_state == StBusy) && !w_acc && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            // Cleared in IDLE so every BUSY entry starts from zero.
            if ((r_state != StBusy) || w_acc) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Final pixel and dropped request in the same cycle give one release.
    assign w_release = (r_state == StBusy) &&
                       ((w_acc && last[r_gidx]) || !req[r_gidx] || w_timeout);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            StIdle: begin
                if (w_win_vld) begin
                    w_state_nxt = StBusy;
                    w_gidx_nxt  = w_win_idx;
                    w_grant_nxt = 4'b0001 << w_win_idx;
                end
            end
            StBusy: begin
                // Always returns through IDLE, so the grant never hops
                // directly between requesters.
                if (w_release) begin
                    w_state_nxt = StIdle;
                    w_grant_nxt = 4'b0000;
                    w_ptr_nxt   = r_gidx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= StIdle;
            r_grant  <= 4'b0000;
            r_gidx   <= 2'd0;
            r_ptr    <= 2'd0;
            r_busy   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_we     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= (w_state_nxt == StBusy);
            r_we    <= w_acc;
            // Coordinates hold their last value between accepted pixels.
            if (w_acc) begin
                r_x      <= x_in[r_gidx*X_W +: X_W];
                r_y      <= y_in[r_gidx*Y_W +: Y_W];
                r_colour <= colour_in[r_gidx*C_W +: C_W];
            end
        end
    end

    assign grant   = r_grant;
    assign busy    = r_busy;
    assign x       = r_x;
    assign y       = r_y;
    assign colour  = r_colour;
    assign writeEn = r_we;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed testbench for plot_arbiter. Inputs change 1 time unit after a
// rising edge and the registered outputs are checked at the same point, so
// each tick() shows the effect of the inputs held during the previous cycle.

module tb_plot_arbiter;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    logic             clk;
    logic             resetn;
    logic [3:0]       req;
    logic [3:0]       last;
    logic [3:0]       we_in;
    logic [4*X_W-1:0] x_in;
    logic [4*Y_W-1:0] y_in;
    logic [4*C_W-1:0] colour_in;
    logic [3:0]       grant;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [C_W-1:0]   colour;
    logic             writeEn;
    logic             busy;
    logic             timeout_err;

    int total = 0;
    int bad   = 0;

    plot_arbiter #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .C_W     (C_W),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .last        (last),
        .we_in       (we_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .colour_in   (colour_in),
        .grant       (grant),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .writeEn     (writeEn),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int k, input int xv, input int yv, input int cv);
        x_in[k*X_W +: X_W]      = X_W'(xv);
        y_in[k*Y_W +: Y_W]      = Y_W'(yv);
        colour_in[k*C_W +: C_W] = C_W'(cv);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req    = 4'b0000;
        we_in  = 4'b0000;
        last   = 4'b0000;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        x_in = '0; y_in = '0; colour_in = '0;
        do_reset();
        tick();
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || writeEn !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: grant=%b busy=%b we=%b want 0000 0 0",
                     grant, busy, writeEn);
        end
        total++;
        if (x !== '0 || y !== '0 || colour !== '0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_pix: x=%0d y=%0d c=%0d terr=%b want 0 0 0 0",
                     x, y, colour, timeout_err);
        end
    endtask

    task automatic test_burst64();
        int npulse;
        int ex, ey, ec;
        npulse = 0;
        req = 4'b0001;
        tick();
        total++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b64_grant: grant=%b busy=%b want 0001 1", grant, busy);
        end
        for (int i = 0; i < 64; i++) begin
            ex = 10 + i % 8; ey = 45 + i / 8; ec = i % 8;
            we_in = 4'b0001;
            last  = (i == 63) ? 4'b0001 : 4'b0000;
            set_pix(0, ex, ey, ec);
            tick();
            if (writeEn === 1'b1) npulse++;
            total++;
            if (writeEn !== 1'b1 || x !== X_W'(ex) || y !== Y_W'(ey) || colour !== C_W'(ec)) begin
                bad++;
                $display("FAIL b64_pix%0d: we=%b x=%0d y=%0d c=%0d want 1 %0d %0d %0d",
                         i, writeEn, x, y, colour, ex, ey, ec);
            end
            total++;
            if (grant !== ((i == 63) ? 4'b0000 : 4'b0001)) begin
                bad++;
                $display("FAIL b64_hold%0d: grant=%b", i, grant);
            end
        end
        we_in = 4'b0000; last = 4'b0000; req = 4'b0000;
        tick();
        total++;
        if (writeEn !== 1'b0 || x !== X_W'(17) || grant !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b64_after: we=%b x=%0d grant=%b busy=%b want 0 17 0000 0",
                     writeEn, x, grant, busy);
        end
        total++;
        if (npulse !== 64) begin
            bad++;
            $display("FAIL b64_count: pulses=%0d want 64", npulse);
        end
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        for (int k = 0; k < 4; k++) set_pix(k, 20 + k, 40 + k, k);
        req = 4'b1111;
        tick();
        for (int b = 0; b < 5; b++) begin
            w = b % 4;
            total++;
            if (grant !== 4'(1 << w) || writeEn !== 1'b0) begin
                bad++;
                $display("FAIL rr_grant%0d: grant=%b we=%b want %b 0",
                         b, grant, writeEn, 4'(1 << w));
            end
            for (int p = 0; p < 2; p++) begin
                we_in = 4'b1111;
                last  = (p == 1) ? 4'b1111 : 4'b0000;
                tick();
                total++;
                if (writeEn !== 1'b1 || x !== X_W'(20 + w) || y !== Y_W'(40 + w)) begin
                    bad++;
                    $display("FAIL rr_pix%0d_%0d: we=%b x=%0d y=%0d want 1 %0d %0d",
                             b, p, writeEn, x, y, 20 + w, 40 + w);
                end
                total++;
                if (grant !== ((p == 1) ? 4'b0000 : 4'(1 << w))) begin
                    bad++;
                    $display("FAIL rr_gap%0d_%0d: grant=%b", b, p, grant);
                end
            end
            we_in = 4'b0000; last = 4'b0000;
            if (b == 4) req = 4'b0000;
            tick();
        end
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL rr_end: grant=%b want 0000", grant);
        end
    endtask

    task automatic test_ignore_others();
        do_reset();
        set_pix(1, 99, 99, 7);
        set_pix(2, 77, 50, 5);
        req   = 4'b0100;
        we_in = 4'b0110;      // requester 2 writes before its grant is visible
        tick();
        total++;
        if (grant !== 4'b0100 || writeEn !== 1'b0) begin
            bad++;
            $display("FAIL ign_grant: grant=%b we=%b want 0100 0", grant, writeEn);
        end
        for (int i = 0; i < 3; i++) begin
            set_pix(2, 30 + i, 50, 5);
            we_in = 4'b0110;
            last  = (i == 2) ? 4'b0110 : 4'b0010;
            tick();
            total++;
            if (writeEn !== 1'b1 || x !== X_W'(30 + i) || colour !== C_W'(5)) begin
                bad++;
                $display("FAIL ign_pix%0d: we=%b x=%0d c=%0d want 1 %0d 5",
                         i, writeEn, x, colour, 30 + i);
            end
        end
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL ign_release: grant=%b want 0000", grant);
        end
        we_in = 4'b0000; last = 4'b0000; req = 4'b0000;
        tick();
    endtask

    task automatic test_req_drop();
        do_reset();
        // Short burst on requester 1 moves the pointer to 2 first.
        req = 4'b0010;
        tick();
        we_in = 4'b0010; last = 4'b0010;
        tick();
        we_in = 4'b0000; last = 4'b0000; req = 4'b1000;
        tick();
        total++;
        if (grant !== 4'b1000) begin
            bad++;
            $display("FAIL drop_grant: grant=%b want 1000", grant);
        end
        for (int i = 0; i < 5; i++) begin
            set_pix(3, 60 + i, 10 + i, 2);
            we_in = 4'b1000;
            tick();
            total++;
            if (writeEn !== 1'b1 || x !== X_W'(60 + i) || y !== Y_W'(10 + i) || grant !== 4'b1000) begin
                bad++;
                $display("FAIL drop_pix%0d: we=%b x=%0d y=%0d grant=%b", i, writeEn, x, y, grant);
            end
        end
        we_in = 4'b0000; req = 4'b0000;
        tick();
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || writeEn !== 1'b0) begin
            bad++;
            $display("FAIL drop_release: grant=%b busy=%b we=%b want 0000 0 0",
                     grant, busy, writeEn);
        end
        req = 4'b1001;
        tick();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL drop_next: grant=%b want 0001", grant);
        end
        req = 4'b0000;
        tick();
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL drop_idle: grant=%b want 0000", grant);
        end
    endtask

    task automatic test_mid_reset();
        // Pointer is 1 here, so a surviving pointer would pick requester 1.
        set_pix(1, 70, 60, 6);
        req = 4'b0010;
        tick();
        we_in = 4'b0010;
        tick();
        total++;
        if (writeEn !== 1'b1 || x !== X_W'(70) || grant !== 4'b0010) begin
            bad++;
            $display("FAIL mr_pix: we=%b x=%0d grant=%b want 1 70 0010", writeEn, x, grant);
        end
        set_pix(1, 71, 61, 4);
        resetn = 1'b0;
        tick();
        total++;
        if (writeEn !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mr_ctrl: we=%b grant=%b busy=%b want 0 0000 0", writeEn, grant, busy);
        end
        total++;
        if (x !== '0 || y !== '0 || colour !== '0) begin
            bad++;
            $display("FAIL mr_pixval: x=%0d y=%0d c=%0d want 0 0 0", x, y, colour);
        end
        resetn = 1'b1; we_in = 4'b0000; req = 4'b0011;
        tick();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL mr_winner: grant=%b want 0001", grant);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_stall();
        logic [3:0] eg;
        logic       ee;
        req = 4'b0001;
        tick();
        set_pix(0, 5, 5, 1);
        we_in = 4'b0001;
        tick();
        total++;
        if (writeEn !== 1'b1 || grant !== 4'b0001) begin
            bad++;
            $display("FAIL stall_pix: we=%b grant=%b want 1 0001", writeEn, grant);
        end
        we_in = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef PLOT_ARBITER_TIMEOUT_EN
            // Released after 16 idle cycles, then re-granted after one IDLE.
            eg = (k == 16) ? 4'b0000 : 4'b0001;
            ee = (k >= 16);
`else
            eg = 4'b0001;
            ee = 1'b0;
`endif
            total++;
            if (grant !== eg || timeout_err !== ee) begin
                bad++;
                $display("FAIL stall_k%0d: grant=%b terr=%b want %b %b", k, grant, timeout_err, eg, ee);
            end
        end
        req = 4'b0000;
        tick();
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL stall_release: grant=%b want 0000", grant);
        end
`ifdef PLOT_ARBITER_TIMEOUT_EN
        tick();
        total++;
        if (timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL stall_sticky: terr=%b want 1", timeout_err);
        end
        do_reset();
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_clear: terr=%b want 0", timeout_err);
        end
`endif
    endtask

    initial begin
        resetn = 1'b0;
        req = 4'b0000; last = 4'b0000; we_in = 4'b0000;
        x_in = '0; y_in = '0; colour_in = '0;
        test_reset();
        test_burst64();
        test_round_robin();
        test_ignore_others();
        test_req_drop();
        test_mid_reset();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Downstream of the sprite plotters: obstacle FSMs, player drawer and background clearer.
- Multiplexes up to four pixel-write streams onto the single VGA adapter write port (x, y, colour, writeEn).
- Grants whole bursts, one sprite per grant, using round-robin priority so that no lane of obstacles starves.
- Registers the selected pixel before it reaches the adapter.

Parameters:
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- C_W, 3, colour width.
- TIMEOUT, 255, idle-write cycles before forced release (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- req  in  4  per-requester burst request, held high until burst ends.
- last  in  4  per-requester flag: current write is final pixel of burst.
- we_in  in  4  per-requester pixel write strobe.
- x_in  in  4*X_W  packed x; requester k at [k*X_W +: X_W].
- y_in  in  4*Y_W  packed y, same packing.
- colour_in  in  4*C_W  packed colour, same packing.
- grant  out  4  one-hot (or zero) burst grant, registered.
- x  out  X_W  pixel x to VGA adapter, registered.
- y  out  Y_W  pixel y, registered.
- colour  out  C_W  pixel colour, registered.
- writeEn  out  1  pixel write strobe to adapter, registered.
- busy  out  1  high while any grant is held.
- timeout_err  out  1  sticky; set on forced release (tied 0 without feature).

Behaviour:
- Reset: clk and resetn are as already decided (resetn synchronous, active-low; clock clk). Reset clears grant, x, y, colour, writeEn, busy and timeout_err to 0, sets state to IDLE, and sets the round-robin pointer to 0 (requester 0 highest priority).
- States: IDLE, BUSY.
- IDLE:
  - If req is nonzero, select the first set bit searching ptr, ptr+1, ... mod 4.
  - Next cycle: grant is one-hot on the winner, busy=1, state BUSY.
  - If req is zero, stay in IDLE.
- BUSY with winner g:
  - A pixel is accepted each cycle where we_in[g]=1.
  - The next cycle, x/y/colour are the slices of g and writeEn=1. Latency is 1 cycle.
  - In cycles with no accepted pixel, writeEn=0 and x/y/colour hold their previous values.
- Release:
  - Trigger: (we_in[g] & last[g]) or req[g]=0.
  - Next cycle: grant=0, busy=0, state IDLE, ptr=(g+1) mod 4.
  - The final pixel is still forwarded when we_in[g] was set.
  - Both conditions in the same cycle cause a single release.
- Non-granted we_in/last are ignored entirely. Writes from a requester before its grant is visible are dropped, not queued.
- There is a mandatory one IDLE cycle between bursts, so grant is never asserted on two requesters and never switches directly from one requester to another.
- Minimum timing: req rises at cycle t, grant rises at t+1, first write can occur at t+1, and writeEn reaches the adapter at t+2.
- A single requester holding req continuously is re-granted after each IDLE cycle.
- Reset asserted mid-burst aborts immediately with reset values. No partial pixel is emitted after reset.
- last without we_in has no effect.

Optional Feature:
- Macro: PLOT_ARBITER_TIMEOUT_EN.
- When defined:
  - A counter runs in BUSY and resets to 0 on each accepted write and on entry to BUSY.
  - When the counter reaches TIMEOUT with no accepted write, grant is released as in normal release, ptr advances, and timeout_err is set.
  - timeout_err is cleared only by reset.
- When undefined: there is no counter, timeout_err is tied 0, and a stalled granted requester holds the port indefinitely.

Test Plan:
- Reset, then req=4'b0001. Requester 0 writes 64 pixels at (10..17, 45..52), last on the 64th. Expect grant=0001 one cycle after req, 64 writeEn pulses each 1 cycle after we_in, and grant=0 the cycle after last.
- req=4'b1111 held, each burst 2 pixels. Expect grant order 0001, 0010, 0100, 1000, 0001, with exactly one cycle of grant=0 between bursts.
- Requester 2 granted; requester 1 drives we_in=1, x=99 during the burst. Expect no output pixel with x=99; only requester 2 coordinates appear.
- Requester 3 granted; deassert req[3] after 5 pixels without last. Expect release the next cycle, ptr=0, and the next winner is 0 when req=4'b1001.
- resetn pulled low for 1 cycle mid-burst. Expect writeEn=0, grant=0, x=y=colour=0 the following cycle, then requester 0 wins first.
- With PLOT_ARBITER_TIMEOUT_EN and TIMEOUT=16: the granted requester stops writing. Expect grant dropped 16 cycles after the last write and timeout_err=1 held until reset. Without the macro, grant remains held and timeout_err=0.
